// File: rtl/ysyx_22050133_lsu_axi_master_if.sv
// AXI4 bus bundle between the LSU bridge (master) and the data-side arbiter port (slave).
// Carries the five AXI channels; clock and reset stay outside the bundle.
interface ysyx_22050133_lsu_axi_master_if #(
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 4
);
  logic                        aw_valid;
  logic                        aw_ready;
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;

  logic                        w_valid;
  logic                        w_ready;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;

  logic                        b_ready;
  logic                        b_valid;
  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;

  logic                        ar_valid;
  logic                        ar_ready;
  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;

  logic                        r_ready;
  logic                        r_valid;
  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [1:0]                  r_resp;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic                        r_last;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    output b_ready,
    input  b_valid, b_id, b_resp,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_ready,
    output r_ready,
    input  r_valid, r_id, r_resp, r_data, r_last
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    input  b_ready,
    output b_valid, b_id, b_resp,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output ar_ready,
    input  r_ready,
    output r_valid, r_id, r_resp, r_data, r_last
  );
endinterface

// File: rtl/ysyx_22050133_lsu_axi_master.sv
// Single-outstanding LSU-to-AXI4 bridge: one request becomes one single-beat read or write.
// Define LSU_AXI_RESP_CHK_EN to report nonzero r_resp/b_resp on rsp_err_o.
module ysyx_22050133_lsu_axi_master #(
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_ID         = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_wen_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [2:0]                  req_size_i,
  input  logic [AXI_DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] req_wmask_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                        rsp_err_o,
  ysyx_22050133_lsu_axi_master_if.master axi
);

`ifdef LSU_AXI_RESP_CHK_EN
  localparam bit RespChkEn = 1'b1;
`else
  localparam bit RespChkEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StRdAr, StRdR, StWrReq, StWrB, StRsp} state_e;

  state_e                      state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]                  size_q, size_d;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [AXI_DATA_WIDTH/8-1:0] wmask_q, wmask_d;
  logic                        ar_valid_q, ar_valid_d;
  logic                        r_ready_q, r_ready_d;
  logic                        aw_valid_q, aw_valid_d;
  logic                        w_valid_q, w_valid_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;
  logic                        b_ready_q, b_ready_d;
  logic                        first_q, first_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                        err_q, err_d;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign ar_hs = ar_valid_q & axi.ar_ready;
  assign r_hs  = r_ready_q & axi.r_valid;
  assign aw_hs = aw_valid_q & axi.aw_ready;
  assign w_hs  = w_valid_q & axi.w_ready;
  assign b_hs  = b_ready_q & axi.b_valid;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    ar_valid_d  = ar_valid_q;
    r_ready_d   = r_ready_q;
    aw_valid_d  = aw_valid_q;
    w_valid_d   = w_valid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    b_ready_d   = b_ready_q;
    first_d     = first_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          size_d  = req_size_i;
          wdata_d = req_wdata_i;
          wmask_d = req_wmask_i;
          if (req_wen_i) begin
            state_d    = StWrReq;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
          end else begin
            state_d    = StRdAr;
            ar_valid_d = 1'b1;
          end
        end
      end
      StRdAr: begin
        if (ar_hs) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          first_d    = 1'b1;
          state_d    = StRdR;
        end
      end
      StRdR: begin
        if (r_hs) begin
          // Only the first beat carries the answer; trailing beats are drained.
          if (first_q) begin
            rdata_d = axi.r_data;
            err_d   = RespChkEn & (|axi.r_resp);
            first_d = 1'b0;
          end
          if (axi.r_last) begin
            r_ready_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = StRsp;
          end
        end
      end
      StWrReq: begin
        if (aw_hs) begin
          aw_valid_d = 1'b0;
          aw_done_d  = 1'b1;
        end
        if (w_hs) begin
          w_valid_d = 1'b0;
          w_done_d  = 1'b1;
        end
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          b_ready_d = 1'b1;
          state_d   = StWrB;
        end
      end
      StWrB: begin
        if (b_hs) begin
          b_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rdata_d     = '0;
          err_d       = RespChkEn & (|axi.b_resp);
          state_d     = StRsp;
        end
      end
      StRsp: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      b_ready_q   <= 1'b0;
      first_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      b_ready_q   <= b_ready_d;
      first_q     <= first_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign req_ready_o = (state_q == StIdle) & ~rst;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  assign axi.aw_valid = aw_valid_q;
  assign axi.aw_id    = AXI_ID_WIDTH'(AXI_ID);
  assign axi.aw_addr  = addr_q;
  assign axi.aw_len   = 8'd0;
  assign axi.aw_size  = size_q;
  assign axi.aw_burst = 2'b01;
  assign axi.w_valid  = w_valid_q;
  assign axi.w_data   = wdata_q;
  assign axi.w_strb   = wmask_q;
  assign axi.w_last   = 1'b1;
  assign axi.b_ready  = b_ready_q;
  assign axi.ar_valid = ar_valid_q;
  assign axi.ar_id    = AXI_ID_WIDTH'(AXI_ID);
  assign axi.ar_addr  = addr_q;
  assign axi.ar_len   = 8'd0;
  assign axi.ar_size  = size_q;
  assign axi.ar_burst = 2'b01;
  assign axi.r_ready  = r_ready_q;

  // Response IDs are deliberately not checked.
  logic unused_ids;
  assign unused_ids = ^{axi.r_id, axi.b_id};

endmodule

// File: tb/tb_ysyx_22050133_lsu_axi_master.sv
// Bench for the LSU AXI bridge: directed and randomized loads/stores against a slave model.
// Expected error flag follows LSU_AXI_RESP_CHK_EN.
module tb_ysyx_22050133_lsu_axi_master;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = 4;

`ifdef LSU_AXI_RESP_CHK_EN
  localparam bit RespChk = 1'b1;
`else
  localparam bit RespChk = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_wen_i;
  logic [AW-1:0]   req_addr_i;
  logic [2:0]      req_size_i;
  logic [DW-1:0]   req_wdata_i;
  logic [DW/8-1:0] req_wmask_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [DW-1:0]   rsp_rdata_o;
  logic            rsp_err_o;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  always #5 clk = ~clk;

  ysyx_22050133_lsu_axi_master_if #(
    .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW)
  ) axi ();

  ysyx_22050133_lsu_axi_master #(
    .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .AXI_ID(1)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_wen_i  (req_wen_i),
    .req_addr_i (req_addr_i),
    .req_size_i (req_size_i),
    .req_wdata_i(req_wdata_i),
    .req_wmask_i(req_wmask_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .axi        (axi.master)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_req();
    req_wen_i   = 1'($urandom);
    req_addr_i  = $urandom;
    req_size_i  = 3'($urandom);
    req_wdata_i = {$urandom, $urandom};
    req_wmask_i = 8'($urandom);
  endtask

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [2:0] size,
                       input logic [63:0] wdata, input logic [7:0] wmask);
    chk("req_ready_idle", req_ready_o, 64'd1);
    req_valid_i = 1'b1;
    req_wen_i   = wen;
    req_addr_i  = addr;
    req_size_i  = size;
    req_wdata_i = wdata;
    req_wmask_i = wmask;
    tick();
    req_valid_i = 1'b0;
    scramble_req();
  endtask

  // Response stalls for dly cycles: payload must hold and further requests are refused.
  task automatic finish_rsp(input logic [63:0] exp_data, input logic exp_err, input int dly);
    for (int c = 0; c <= dly; c++) begin
      chk("rsp_valid_hold", rsp_valid_o, 64'd1);
      chk("rsp_rdata", rsp_rdata_o, exp_data);
      chk("rsp_err", rsp_err_o, 64'(exp_err));
      chk("req_ready_busy", req_ready_o, 64'd0);
      chk("no_new_txn", {axi.ar_valid, axi.aw_valid, axi.w_valid}, 64'd0);
      rsp_ready_i = (c == dly);
      req_valid_i = (c < dly);
      tick();
    end
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    chk("rsp_valid_drop", rsp_valid_o, 64'd0);
    chk("req_ready_back", req_ready_o, 64'd1);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [2:0] size, input int nbeats,
                         input int ar_dly, input int gap, input int rsp_dly,
                         input logic [63:0] first_data, input logic [1:0] resp0);
    logic [63:0] beats[$];
    logic        exp_err;
    beats.push_back(first_data);
    for (int i = 1; i < nbeats; i++) beats.push_back({$urandom, $urandom});
    exp_err = RespChk && (resp0 != 2'd0);
    issue(1'b0, addr, size, 64'd0, 8'd0);
    for (int c = 0; c <= ar_dly; c++) begin
      chk("ar_valid", axi.ar_valid, 64'd1);
      chk("ar_addr", axi.ar_addr, 64'(addr));
      chk("ar_size", axi.ar_size, 64'(size));
      chk("ar_len_burst_id", {axi.ar_len, axi.ar_burst, axi.ar_id}, {50'd0, 8'd0, 2'b01, 4'd1});
      chk("r_ready_early", axi.r_ready, 64'd0);
      axi.ar_ready = (c == ar_dly);
      tick();
    end
    axi.ar_ready = 1'b0;
    chk("ar_valid_drop", axi.ar_valid, 64'd0);
    for (int b = 0; b < nbeats; b++) begin
      for (int g = 0; g < gap; g++) begin
        chk("r_ready_gap", axi.r_ready, 64'd1);
        tick();
      end
      chk("r_ready", axi.r_ready, 64'd1);
      chk("rsp_early", rsp_valid_o, 64'd0);
      axi.r_valid = 1'b1;
      axi.r_data  = beats[b];
      axi.r_last  = (b == nbeats - 1);
      axi.r_resp  = (b == 0) ? resp0 : 2'($urandom);
      axi.r_id    = 4'($urandom);
      tick();
      axi.r_valid = 1'b0;
      axi.r_last  = 1'b0;
    end
    chk("r_ready_drop", axi.r_ready, 64'd0);
    finish_rsp(beats[0], exp_err, rsp_dly);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [2:0] size,
                          input logic [63:0] wdata, input logic [7:0] wmask,
                          input int aw_dly, input int w_dly, input int b_dly, input int rsp_dly,
                          input logic [1:0] bresp);
    logic aw_pend, w_pend;
    int   c;
    issue(1'b1, addr, size, wdata, wmask);
    aw_pend = 1'b1;
    w_pend  = 1'b1;
    c = 0;
    while ((aw_pend || w_pend) && c < 20) begin
      chk("aw_valid", axi.aw_valid, 64'(aw_pend));
      chk("w_valid", axi.w_valid, 64'(w_pend));
      chk("b_ready_early", axi.b_ready, 64'd0);
      if (aw_pend) begin
        chk("aw_addr", axi.aw_addr, 64'(addr));
        chk("aw_size_len_burst_id", {axi.aw_size, axi.aw_len, axi.aw_burst, axi.aw_id},
            {47'd0, size, 8'd0, 2'b01, 4'd1});
      end
      if (w_pend) begin
        chk("w_data", axi.w_data, wdata);
        chk("w_strb_last", {axi.w_strb, axi.w_last}, {55'd0, wmask, 1'b1});
      end
      axi.aw_ready = (c >= aw_dly);
      axi.w_ready  = (c >= w_dly);
      tick();
      if (c >= aw_dly) aw_pend = 1'b0;
      if (c >= w_dly) w_pend = 1'b0;
      c++;
    end
    axi.aw_ready = 1'b0;
    axi.w_ready  = 1'b0;
    chk("aw_w_valid_drop", {axi.aw_valid, axi.w_valid}, 64'd0);
    for (int k = 0; k <= b_dly; k++) begin
      chk("b_ready", axi.b_ready, 64'd1);
      chk("rsp_early_wr", rsp_valid_o, 64'd0);
      axi.b_valid = (k == b_dly);
      axi.b_resp  = (k == b_dly) ? bresp : 2'($urandom);
      axi.b_id    = 4'($urandom);
      tick();
    end
    axi.b_valid = 1'b0;
    chk("b_ready_drop", axi.b_ready, 64'd0);
    finish_rsp(64'd0, RespChk && (bresp != 2'd0), rsp_dly);
  endtask

  initial begin
    rst         = 1'b1;
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    scramble_req();
    axi.aw_ready = 1'b0;
    axi.w_ready  = 1'b0;
    axi.b_valid  = 1'b0;
    axi.b_id     = '0;
    axi.b_resp   = '0;
    axi.ar_ready = 1'b0;
    axi.r_valid  = 1'b0;
    axi.r_id     = '0;
    axi.r_resp   = '0;
    axi.r_data   = '0;
    axi.r_last   = 1'b0;
    tick();
    tick();
    chk("rst_valids",
        {axi.ar_valid, axi.r_ready, axi.aw_valid, axi.w_valid, axi.b_ready, rsp_valid_o}, 64'd0);
    chk("rst_rsp", {rsp_err_o, rsp_rdata_o != 64'd0}, 64'd0);
    chk("rst_req_ready", req_ready_o, 64'd0);
    rst = 1'b0;
    tick();
    chk("req_ready_after_rst", req_ready_o, 64'd1);

    // Best-case load, then delayed-AW store, same-cycle store with SLVERR-class resp.
    do_load(32'h8000_0010, 3'd3, 1, 0, 0, 0, 64'h1122_3344_5566_7788, 2'd0);
    do_store(32'h8000_0020, 3'd0, 64'h0000_0000_0000_00AB, 8'h01, 3, 0, 0, 0, 2'd0);
    do_store(32'h8000_0028, 3'd3, {$urandom, $urandom}, 8'hFF, 0, 0, 0, 0, 2'd2);
    do_store(32'h8000_0030, 3'd2, {$urandom, $urandom}, 8'h0F, 0, 2, 1, 0, 2'd0);
    do_load(32'h8000_0040, 3'd3, 3, 0, 0, 0, 64'h1, 2'd0);
    do_load(32'h8000_0048, 3'd2, 1, 1, 1, 5, {$urandom, $urandom}, 2'd3);

    // Reset while waiting for R must abort cleanly.
    issue(1'b0, 32'h8000_0050, 3'd3, 64'd0, 8'd0);
    axi.ar_ready = 1'b1;
    tick();
    axi.ar_ready = 1'b0;
    chk("rd_r_before_rst", axi.r_ready, 64'd1);
    rst          = 1'b1;
    axi.r_valid  = 1'b1;
    axi.r_last   = 1'b1;
    axi.r_data   = 64'hDEAD_BEEF_0000_0001;
    tick();
    axi.r_valid = 1'b0;
    axi.r_last  = 1'b0;
    chk("mid_rst_valids",
        {axi.ar_valid, axi.r_ready, axi.aw_valid, axi.w_valid, axi.b_ready, rsp_valid_o}, 64'd0);
    chk("mid_rst_req_ready", req_ready_o, 64'd0);
    rst = 1'b0;
    tick();
    chk("req_ready_after_mid_rst", req_ready_o, 64'd1);
    chk("no_rsp_after_mid_rst", rsp_valid_o, 64'd0);

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(1, 0) == 1) begin
        do_load($urandom, 3'($urandom_range(3, 0)), $urandom_range(4, 1), $urandom_range(3, 0),
                $urandom_range(2, 0), $urandom_range(3, 0), {$urandom, $urandom},
                2'($urandom));
      end else begin
        do_store($urandom, 3'($urandom_range(3, 0)), {$urandom, $urandom}, 8'($urandom),
                 $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                 $urandom_range(3, 0), 2'($urandom));
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
